// File: rtl/spi_sram_slave_model.sv
// spi_sram_slave_model: clk-oversampled SPI mode-0 SRAM stand-in (READ/WRITE/RDMR/WRMR).
// Serves an internal byte array in byte, page or sequential mode.
// Ports: clk, rst_n (async, active low); spi_sck/spi_cs_n/spi_si in;
//   spi_so/spi_so_oe out; mode_o = mode reg [7:6]; cmd_err = bad-command pulse.
// Macro SPI_SRAM_FAST_READ_EN adds command 0x0B (8 dummy clocks before data).
module spi_sram_slave_model #(
  parameter int         DEPTH      = 1024,
  parameter int         ADDR_BYTES = 2,
  parameter int         PAGE_SIZE  = 32,
  parameter logic [1:0] MODE_RST   = 2'b01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_si,
  output logic       spi_so,
  output logic       spi_so_oe,
  output logic [1:0] mode_o,
  output logic       cmd_err
);
  localparam int AW    = $clog2(DEPTH);
  localparam int ABITS = ADDR_BYTES * 8;
  localparam logic [AW-1:0] PMASK = AW'(PAGE_SIZE - 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CMD     = 4'd1;
  localparam logic [3:0] S_ADDR    = 4'd2;
  localparam logic [3:0] S_DATA_WR = 4'd3;
  localparam logic [3:0] S_DATA_RD = 4'd4;
  localparam logic [3:0] S_MODE_WR = 4'd5;
  localparam logic [3:0] S_MODE_RD = 4'd6;
  localparam logic [3:0] S_IGNORE  = 4'd7;
`ifdef SPI_SRAM_FAST_READ_EN
  localparam logic [3:0] S_DUMMY   = 4'd8;
  localparam logic [1:0] OP_FR     = 2'd2;
`endif
  localparam logic [1:0] OP_WR     = 2'd0;
  localparam logic [1:0] OP_RD     = 2'd1;

  logic [2:0]       r_sck_sync;
  logic [1:0]       r_cs_sync;
  logic [1:0]       r_si_sync;
  logic [3:0]       r_state;
  logic [1:0]       r_op;
  logic [5:0]       r_cnt;
  logic [ABITS-2:0] r_in;
  logic [7:0]       r_out;
  logic [AW-1:0]    r_addr;
  logic [1:0]       r_mode;
  logic             r_so;
  logic             r_oe;
  logic             r_err;
  logic [7:0]       r_mem [DEPTH];

  logic             w_rise;
  logic             w_fall;
  logic             w_cs;
  logic [ABITS-1:0] w_in_next;
  logic [AW-1:0]    w_addr_in;
  logic [AW-1:0]    w_addr_inc;
  logic [AW-1:0]    w_next_addr;
  logic             w_last8;
  logic             w_we;
  logic             w_unused;

  assign w_rise    = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_fall    = ~r_sck_sync[1] & r_sck_sync[2];
  assign w_cs      = r_cs_sync[1];
  assign w_in_next = {r_in, r_si_sync[1]};
  assign w_addr_in = w_in_next[AW-1:0];
  assign w_last8   = (r_cnt == 6'd7);
  assign w_unused  = ^w_in_next;

  // Page mode wraps only the in-page offset bits.
  assign w_addr_inc  = r_addr + AW'(1);
  assign w_next_addr = (r_mode == 2'b10)
                     ? ((r_addr & ~PMASK) | (w_addr_inc & PMASK))
                     : w_addr_inc;

  assign w_we = !w_cs && w_rise && (r_state == S_DATA_WR) && w_last8;

  assign spi_so    = r_so;
  assign spi_so_oe = r_oe;
  assign mode_o    = r_mode;
  assign cmd_err   = r_err;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_addr] <= w_in_next[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync <= 3'b000;
      r_cs_sync  <= 2'b11;
      r_si_sync  <= 2'b00;
    end else begin
      r_sck_sync <= {r_sck_sync[1:0], spi_sck};
      r_cs_sync  <= {r_cs_sync[0], spi_cs_n};
      r_si_sync  <= {r_si_sync[0], spi_si};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_WR;
      r_cnt   <= '0;
      r_in    <= '0;
      r_out   <= '0;
      r_addr  <= '0;
      r_mode  <= MODE_RST;
      r_so    <= 1'b0;
      r_oe    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      // Deselect wins over any coincident sck edge.
      if (w_cs) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_so    <= 1'b0;
        r_oe    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_CMD: begin
            if (w_rise) begin
              r_in  <= w_in_next[ABITS-2:0];
              r_cnt <= r_cnt + 6'd1;
              if (w_last8) begin
                r_cnt <= '0;
                case (w_in_next[7:0])
                  8'h02: begin
                    r_state <= S_ADDR;
                    r_op    <= OP_WR;
                  end
                  8'h03: begin
                    r_state <= S_ADDR;
                    r_op    <= OP_RD;
                  end
`ifdef SPI_SRAM_FAST_READ_EN
                  8'h0B: begin
                    r_state <= S_ADDR;
                    r_op    <= OP_FR;
                  end
`endif
                  8'h01: r_state <= S_MODE_WR;
                  8'h05: begin
                    r_state <= S_MODE_RD;
                    r_out   <= {r_mode, 6'b0};
                  end
                  default: begin
                    r_state <= S_IGNORE;
                    r_err   <= 1'b1;
                  end
                endcase
              end else begin
                r_state <= S_CMD;
              end
            end else begin
              r_state <= S_CMD;
            end
          end
          S_ADDR: begin
            if (w_rise) begin
              r_in  <= w_in_next[ABITS-2:0];
              r_cnt <= r_cnt + 6'd1;
              if (r_cnt == 6'(ABITS - 1)) begin
                r_cnt  <= '0;
                r_addr <= w_addr_in;
                if (r_op == OP_WR) begin
                  r_state <= S_DATA_WR;
`ifdef SPI_SRAM_FAST_READ_EN
                end else if (r_op == OP_FR) begin
                  r_state <= S_DUMMY;
`endif
                end else begin
                  r_state <= S_DATA_RD;
                  r_out   <= r_mem[w_addr_in];
                end
              end
            end
          end
`ifdef SPI_SRAM_FAST_READ_EN
          S_DUMMY: begin
            if (w_rise) begin
              r_cnt <= r_cnt + 6'd1;
              if (w_last8) begin
                r_cnt   <= '0;
                r_state <= S_DATA_RD;
                r_out   <= r_mem[r_addr];
              end
            end
          end
`endif
          S_DATA_WR: begin
            if (w_rise) begin
              r_in  <= w_in_next[ABITS-2:0];
              r_cnt <= r_cnt + 6'd1;
              if (w_last8) begin
                r_cnt <= '0;
                if (r_mode == 2'b00) r_state <= S_IGNORE;
                else r_addr <= w_next_addr;
              end
            end
          end
          S_DATA_RD: begin
            if (w_fall) begin
              r_so  <= r_out[7];
              r_out <= {r_out[6:0], 1'b0};
              r_oe  <= 1'b1;
            end else if (w_rise) begin
              r_cnt <= r_cnt + 6'd1;
              if (w_last8) begin
                r_cnt <= '0;
                if (r_mode == 2'b00) begin
                  r_state <= S_IGNORE;
                  r_so    <= 1'b0;
                  r_oe    <= 1'b0;
                end else begin
                  r_addr <= w_next_addr;
                  r_out  <= r_mem[w_next_addr];
                end
              end
            end
          end
          S_MODE_WR: begin
            if (w_rise) begin
              r_in  <= w_in_next[ABITS-2:0];
              r_cnt <= r_cnt + 6'd1;
              if (w_last8) begin
                r_cnt   <= '0;
                r_mode  <= w_in_next[7:6];
                r_state <= S_IGNORE;
              end
            end
          end
          S_MODE_RD: begin
            if (w_fall) begin
              r_so  <= r_out[7];
              r_out <= {r_out[6:0], 1'b0};
              r_oe  <= 1'b1;
            end
          end
          default: begin
            r_so <= 1'b0;
            r_oe <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_sram_slave_model.sv
// tb_spi_sram_slave_model: directed SPI transactions against a
// byte-array/mode model; per-bit so/oe checks plus literal pins.
module tb_spi_sram_slave_model;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_si;
  logic       spi_so;
  logic       spi_so_oe;
  logic [1:0] mode_o;
  logic       cmd_err;

  int n_chk = 0;
  int n_err = 0;
  int n_pulse = 0;

  logic [7:0] m_mem [1024];
  logic [1:0] m_mode;
  logic       e_chk = 1'b0;
  logic       e_oe = 1'b0;
  logic       e_so_chk = 1'b0;
  logic       e_so = 1'b0;
  logic [7:0] rxb [8];

  always #5 clk = ~clk;

  spi_sram_slave_model dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_sck   (spi_sck),
    .spi_cs_n  (spi_cs_n),
    .spi_si    (spi_si),
    .spi_so    (spi_so),
    .spi_so_oe (spi_so_oe),
    .mode_o    (mode_o),
    .cmd_err   (cmd_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int m_adv(input int a);
    if (m_mode == 2'b10) return (a & ~31) | ((a + 1) & 31);
    return (a + 1) % 1024;
  endfunction

  // Compare process: master samples at sck rise.
  always @(posedge spi_sck) begin
    if (e_chk) chk("so_oe", 32'(spi_so_oe), 32'(e_oe));
    if (e_so_chk) chk("so", 32'(spi_so), 32'(e_so));
  end

  always @(posedge spi_cs_n) begin
    #25;
    if (rst_n) chk("mode_o", 32'(mode_o), 32'(m_mode));
  end

  always @(negedge clk) if (rst_n && cmd_err) n_pulse++;

  task automatic bit_xfer(input logic b, input logic c, input logic eo,
                          input logic sc, input logic es,
                          output logic r);
    spi_si = b;
    e_chk = c;
    e_oe = eo;
    e_so_chk = sc;
    e_so = es;
    #40;
    r = spi_so;
    spi_sck = 1'b1;
    #40;
    spi_sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], 1'b1, 1'b0, 1'b1, 1'b0, r);
  endtask

  task automatic recv_byte(input logic eo, input logic [7:0] e,
                           output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b0, 1'b1, eo, 1'b1, e[i], r);
      rx[i] = r;
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    #80;
  endtask

  task automatic cs_end();
    #40;
    spi_cs_n = 1'b1;
    e_chk = 1'b0;
    e_so_chk = 1'b0;
    #60;
    chk("oe_idle", 32'(spi_so_oe), 32'd0);
    #40;
  endtask

  task automatic do_write(input int a, input logic [7:0] d0,
                          input logic [7:0] d1, input int n);
    int addr;
    logic [7:0] b;
    addr = a % 1024;
    cs_begin();
    send_byte(8'h02);
    send_byte(8'(a >> 8));
    send_byte(8'(a));
    for (int k = 0; k < n; k++) begin
      b = (k == 0) ? d0 : d1;
      send_byte(b);
      if (!(m_mode == 2'b00 && k > 0)) begin
        m_mem[addr] = b;
        addr = m_adv(addr);
      end
    end
    cs_end();
  endtask

  task automatic do_read(input int a, input int n, input logic fast);
    int addr;
    logic r;
    logic [7:0] rx;
    addr = a % 1024;
    cs_begin();
    send_byte(fast ? 8'h0B : 8'h03);
    send_byte(8'(a >> 8));
    send_byte(8'(a));
    if (fast)
      for (int i = 0; i < 8; i++) bit_xfer(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, r);
    for (int k = 0; k < n; k++) begin
      if (m_mode == 2'b00 && k > 0) begin
        recv_byte(1'b0, 8'h00, rx);
      end else begin
        recv_byte(1'b1, m_mem[addr], rx);
        addr = m_adv(addr);
      end
      rxb[k] = rx;
    end
    cs_end();
  endtask

  task automatic do_wrmr(input logic [7:0] b);
    cs_begin();
    send_byte(8'h01);
    send_byte(b);
    m_mode = b[7:6];
    cs_end();
  endtask

  task automatic do_rdmr(input int n);
    logic [7:0] rx;
    cs_begin();
    send_byte(8'h05);
    for (int k = 0; k < n; k++) begin
      recv_byte(1'b1, (k == 0) ? {m_mode, 6'b0} : 8'h00, rx);
      rxb[k] = rx;
    end
    cs_end();
  endtask

  initial begin
    logic r;
    int p0;
    logic [7:0] lit;
    rst_n = 1'b0;
    spi_sck = 1'b0;
    spi_cs_n = 1'b1;
    spi_si = 1'b0;
    m_mode = 2'b01;
    #21;
    chk("rst_so", 32'(spi_so), 32'd0);
    chk("rst_oe", 32'(spi_so_oe), 32'd0);
    chk("rst_mode", 32'(mode_o), 32'd1);
    chk("rst_err", 32'(cmd_err), 32'd0);
    #9;
    rst_n = 1'b1;
    #40;

    do_write(16'h0020, 8'hEE, 8'h00, 1);
    do_write(16'h0040, 8'h00, 8'h99, 2);
    do_write(16'h0005, 8'hC7, 8'h00, 1);

    do_write(16'h0010, 8'hA5, 8'h3C, 2);
    do_read(16'h0010, 2, 1'b0);
    chk("rd10_b0", 32'(rxb[0]), 32'hA5);
    chk("rd10_b1", 32'(rxb[1]), 32'h3C);
    chk("mode_seq", 32'(mode_o), 32'd1);

    do_write(16'h03FF, 8'h11, 8'h22, 2);
    do_read(16'h03FF, 2, 1'b0);
    chk("wrap_b0", 32'(rxb[0]), 32'h11);
    chk("wrap_b1", 32'(rxb[1]), 32'h22);
    do_read(16'h0000, 1, 1'b0);
    chk("mem0", 32'(rxb[0]), 32'h22);

    do_wrmr(8'h80);
    chk("mode_page", 32'(mode_o), 32'd2);
    do_rdmr(2);
    chk("rdmr_b0", 32'(rxb[0]), 32'h80);
    chk("rdmr_b1", 32'(rxb[1]), 32'h00);

    do_write(16'h001F, 8'h77, 8'h88, 2);
    do_read(16'h001F, 2, 1'b0);
    chk("page_b0", 32'(rxb[0]), 32'h77);
    chk("page_b1", 32'(rxb[1]), 32'h88);
    do_read(16'h0020, 1, 1'b0);
    chk("page_20", 32'(rxb[0]), 32'hEE);

    do_wrmr(8'h00);
    chk("mode_byte", 32'(mode_o), 32'd0);
    do_read(16'h0005, 3, 1'b0);
    chk("byte_b0", 32'(rxb[0]), 32'hC7);
    chk("byte_b1", 32'(rxb[1]), 32'h00);
    chk("byte_b2", 32'(rxb[2]), 32'h00);

    do_wrmr(8'h40);
    cs_begin();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h40);
    send_byte(8'h5A);
    lit = 8'hB0;
    for (int i = 7; i >= 4; i--) bit_xfer(lit[i], 1'b1, 1'b0, 1'b1, 1'b0, r);
    cs_end();
    m_mem[16'h040] = 8'h5A;
    do_read(16'h0040, 2, 1'b0);
    chk("part_40", 32'(rxb[0]), 32'h5A);
    chk("part_41", 32'(rxb[1]), 32'h99);

    p0 = n_pulse;
    cs_begin();
    send_byte(8'h9F);
    send_byte(8'h00);
    cs_end();
    chk("err_9f", 32'(n_pulse - p0), 32'd1);

`ifdef SPI_SRAM_FAST_READ_EN
    do_read(16'h0010, 1, 1'b1);
    chk("fast_rd", 32'(rxb[0]), 32'hA5);
`else
    p0 = n_pulse;
    cs_begin();
    send_byte(8'h0B);
    cs_end();
    chk("err_0b", 32'(n_pulse - p0), 32'd1);
`endif

    do_wrmr(8'h80);
    cs_begin();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h10);
    lit = 8'hA5;
    for (int i = 7; i >= 5; i--) bit_xfer(1'b0, 1'b1, 1'b1, 1'b1, lit[i], r);
    e_chk = 1'b0;
    e_so_chk = 1'b0;
    #20;
    rst_n = 1'b0;
    m_mode = 2'b01;
    #1;
    chk("mid_rst_so", 32'(spi_so), 32'd0);
    chk("mid_rst_oe", 32'(spi_so_oe), 32'd0);
    chk("mid_rst_mode", 32'(mode_o), 32'd1);
    #19;
    rst_n = 1'b1;
    #20;
    cs_end();
    do_read(16'h0010, 1, 1'b0);
    chk("post_rst", 32'(rxb[0]), 32'hA5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
